flag_sequencer: RTL

Owns the 6-bit processor status flags and sequences every write to them. Merges ALU flag results (per-bit masked), explicit flag loads from the data bus, and interrupt save/restore through a small LIFO shadow stack. Exposes the current flags and a registered-source branch-condition result to the control unit. Replaces the bare flag register in the datapath.

---
 rtl/flag_pkg.sv | 25 ++
 rtl/flag_sequencer_if.sv | 38 +++
 rtl/flag_stack.sv | 53 +++++
 rtl/flag_sequencer.sv | 86 ++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared flag width, flag bit positions and branch-condition encodings.
// Used by the flag sequencer top, its shadow stack and its interface.
package flag_pkg;

  localparam int FLAG_W = 6;

  localparam int FLG_C  = 0;
  localparam int FLG_Z  = 1;
  localparam int FLG_S  = 2;
  localparam int FLG_GT = 3;
  localparam int FLG_EQ = 4;
  localparam int FLG_P  = 5;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_C      = 3'd1,
    COND_Z      = 3'd2,
    COND_NZ     = 3'd3,
    COND_S      = 3'd4,
    COND_GT     = 3'd5,
    COND_EQ     = 3'd6,
    COND_P      = 3'd7
  } cond_e;

endpackage

// File: rtl/flag_sequencer_if.sv
// Flag sequencer control/status bundle; master = control unit, slave = sequencer.
// Status outputs are registered except cond_true; no backpressure signals.
interface flag_sequencer_if
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] alu_mask;
  logic              ld_valid;
  logic [FLAG_W-1:0] ld_flags;
  logic              save_req;
  logic              restore_req;
  logic              err_clr;
  logic [2:0]        cond_sel;
  logic [FLAG_W-1:0] flags;
  logic              cond_true;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output alu_valid, alu_flags, alu_mask, ld_valid, ld_flags,
           save_req, restore_req, err_clr, cond_sel,
    input  flags, cond_true, depth, full, empty, err
  );

  modport slave (
    input  alu_valid, alu_flags, alu_mask, ld_valid, ld_flags,
           save_req, restore_req, err_clr, cond_sel,
    output flags, cond_true, depth, full, empty, err
  );

endinterface

// File: rtl/flag_stack.sv
// LIFO shadow stack for flags; push/pop take effect on the next edge, top entry is combinational.
// Never stalls: push while full or pop while empty is dropped and reported as a one-cycle err_pulse.
module flag_stack
  import flag_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] push_dat,
  output logic [FLAG_W-1:0] top_dat,
  output logic [DW-1:0]     depth,
  output logic              full,
  output logic              empty,
  output logic              pop_ok,
  output logic              err_pulse
);

  logic [FLAG_W-1:0] mem [DEPTH];
  logic [DW-1:0]     sp;
  logic              push_ok;

  assign full      = (sp == DW'(DEPTH));
  assign empty     = (sp == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign err_pulse = (push & full) | (pop & empty);
  assign depth     = sp;

  // sp points one past the top; the low bits wrap correctly when sp == DEPTH.
  assign top_dat   = mem[sp[AW-1:0] - AW'(1)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (push_ok) begin
      sp <= sp + DW'(1);
    end else if (pop_ok) begin
      sp <= sp - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[sp[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/flag_sequencer.sv
// Processor status flag register: merges restore > load > masked ALU update, saves to a shadow stack.
// One-cycle update latency, cond_true combinational from current flags; never stalls, errors are sticky.
module flag_sequencer
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  flag_sequencer_if.slave  bus
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] merge_flags;
  logic [FLAG_W-1:0] next_flags;
  logic [FLAG_W-1:0] top_dat;
  logic              conflict;
  logic              stk_push;
  logic              stk_pop;
  logic              pop_ok;
  logic              stk_err;
  logic              err_q;
  logic              cond;

  // Simultaneous save and restore executes neither; only the error is raised.
  assign conflict = bus.save_req & bus.restore_req;
  assign stk_push = bus.save_req & ~bus.restore_req;
  assign stk_pop  = bus.restore_req & ~bus.save_req;

  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_dat  (merge_flags),
    .top_dat   (top_dat),
    .depth     (bus.depth),
    .full      (bus.full),
    .empty     (bus.empty),
    .pop_ok    (pop_ok),
    .err_pulse (stk_err)
  );

  // merge_flags is also what a save captures, so a save never sees the restore path.
  always_comb begin
    merge_flags = flags_q;
    if (bus.ld_valid) begin
      merge_flags = bus.ld_flags;
    end else if (bus.alu_valid) begin
      merge_flags = (flags_q & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);
    end
    next_flags = pop_ok ? top_dat : merge_flags;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= next_flags;
      err_q   <= (err_q & ~bus.err_clr) | stk_err | conflict;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (cond_e'(bus.cond_sel))
      COND_ALWAYS: cond = 1'b1;
      COND_C:      cond = flags_q[FLG_C];
      COND_Z:      cond = flags_q[FLG_Z];
      COND_NZ:     cond = ~flags_q[FLG_Z];
      COND_S:      cond = flags_q[FLG_S];
      COND_GT:     cond = flags_q[FLG_GT];
      COND_EQ:     cond = flags_q[FLG_EQ];
      COND_P:      cond = flags_q[FLG_P];
      default:     cond = 1'b0;
    endcase
  end

  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
  assign bus.cond_true = cond;

endmodule
